mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: MemAccess

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_load_format.sv | 24 ++
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared FSM state type, funct3 codes and access fault check for mem_access
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Sizes 3/6/7 have no meaning for loads; stores with those codes use the mask as given.
  function automatic logic access_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_load);
    logic fault;
    fault = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = addr_lo[0];
      F3_LW:         fault = (addr_lo != 2'b00);
      default:       fault = is_load;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mem_access_load_format.sv
// rtl/mem_access_load_format.sv - combinational load lane extraction and sign/zero extension
module mem_access_load_format
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  data_o = {24'h0, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit bridging the Execute stage to a req/ready/rvalid data bus
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_data_in,
  input  logic [7:0]  mem_mask_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  output logic        stall_out,
  output logic        dbus_req_out,
  output logic        dbus_we_out,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wstrb_out,
  input  logic        dbus_ready_in,
  input  logic        dbus_rvalid_in,
  input  logic [31:0] dbus_rdata_in,
  output logic        load_valid_out,
  output logic [31:0] load_data_out,
  output logic [4:0]  load_rd_out,
  output logic        misalign_out,
  output logic        timeout_out
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [29:0]     word_addr_q;
  logic [1:0]      offset_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            misalign_q, misalign_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     load_data_q;
  logic [4:0]      load_rd_q;
  logic            accept, fault, expired;
  logic [31:0]     fmt_data;
  logic            unused_mask_hi;

  assign unused_mask_hi = ^mem_mask_in[7:4];

  assign accept  = (state_q == ST_IDLE) && (mem_write_in || mem_read_in);
  assign fault   = accept && access_fault(funct3_in, mem_addr_in[1:0], !mem_write_in);
  assign expired = (cnt_q == CNT_LAST);

  // A bus handshake in the expiring cycle completes the transaction rather than timing it out.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fault) begin
          misalign_d = 1'b1;
        end else if (accept) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (dbus_ready_in) begin
          state_d = we_q ? ST_IDLE : ST_WAIT;
        end else if (expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (dbus_rvalid_in) begin
          state_d = ST_RESP;
        end else if (expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      word_addr_q <= '0;
      offset_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      rd_q        <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      load_data_q <= '0;
      load_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      if (accept && !fault) begin
        word_addr_q <= mem_addr_in[31:2];
        offset_q    <= mem_addr_in[1:0];
        wdata_q     <= mem_data_in << {mem_addr_in[1:0], 3'b000};
        wstrb_q     <= mem_mask_in[3:0] << mem_addr_in[1:0];
        we_q        <= mem_write_in;
        funct3_q    <= funct3_in;
        rd_q        <= rd_in;
      end
      if (state_q == ST_WAIT && dbus_rvalid_in) begin
        load_data_q <= fmt_data;
        load_rd_q   <= rd_q;
      end
    end
  end

  mem_access_load_format u_load_format (
    .rdata_i  (dbus_rdata_in),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (fmt_data)
  );

  assign stall_out      = (state_q != ST_IDLE);
  assign dbus_req_out   = (state_q == ST_REQ);
  assign dbus_we_out    = dbus_req_out & we_q;
  assign dbus_addr_out  = {word_addr_q, 2'b00};
  assign dbus_wdata_out = wdata_q;
  assign dbus_wstrb_out = wstrb_q;
  assign load_valid_out = (state_q == ST_RESP);
  assign load_data_out  = load_data_q;
  assign load_rd_out    = load_rd_q;
  assign misalign_out   = misalign_q;
  assign timeout_out    = timeout_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with a short bus timeout
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_in, mem_read_in;
  logic [31:0] mem_addr_in, mem_data_in;
  logic [7:0]  mem_mask_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        stall_out, dbus_req_out, dbus_we_out;
  logic [31:0] dbus_addr_out, dbus_wdata_out;
  logic [3:0]  dbus_wstrb_out;
  logic        dbus_ready_in, dbus_rvalid_in;
  logic [31:0] dbus_rdata_in;
  logic        load_valid_out;
  logic [31:0] load_data_out;
  logic [4:0]  load_rd_out;
  logic        misalign_out, timeout_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } ld_exp_t;

  bus_exp_t bus_q[$];
  ld_exp_t  ld_q[$];

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_write_in   (mem_write_in),
    .mem_read_in    (mem_read_in),
    .mem_addr_in    (mem_addr_in),
    .mem_data_in    (mem_data_in),
    .mem_mask_in    (mem_mask_in),
    .funct3_in      (funct3_in),
    .rd_in          (rd_in),
    .stall_out      (stall_out),
    .dbus_req_out   (dbus_req_out),
    .dbus_we_out    (dbus_we_out),
    .dbus_addr_out  (dbus_addr_out),
    .dbus_wdata_out (dbus_wdata_out),
    .dbus_wstrb_out (dbus_wstrb_out),
    .dbus_ready_in  (dbus_ready_in),
    .dbus_rvalid_in (dbus_rvalid_in),
    .dbus_rdata_in  (dbus_rdata_in),
    .load_valid_out (load_valid_out),
    .load_data_out  (load_data_out),
    .load_rd_out    (load_rd_out),
    .misalign_out   (misalign_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (dbus_req_out && dbus_ready_in) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: addr=%h we=%b, required no request", dbus_addr_out, dbus_we_out);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          if ({dbus_addr_out, dbus_wdata_out, dbus_wstrb_out, dbus_we_out} !==
              {e.addr, e.wdata, e.wstrb, e.we}) begin
            errors++;
            $display("FAIL bus_req: got addr=%h wdata=%h wstrb=%h we=%b, required addr=%h wdata=%h wstrb=%h we=%b",
                     dbus_addr_out, dbus_wdata_out, dbus_wstrb_out, dbus_we_out,
                     e.addr, e.wdata, e.wstrb, e.we);
          end
        end
      end
      if (load_valid_out) begin
        checks++;
        if (ld_q.size() == 0) begin
          errors++;
          $display("FAIL load_unexpected: data=%h rd=%0d, required no load result", load_data_out, load_rd_out);
        end else begin
          ld_exp_t l;
          l = ld_q.pop_front();
          if (load_data_out !== l.data || load_rd_out !== l.rd) begin
            errors++;
            $display("FAIL load_result: got data=%h rd=%0d, required data=%h rd=%0d",
                     load_data_out, load_rd_out, l.data, l.rd);
          end
        end
      end
    end
  end

  // Called at posedge+1; the following edge is the accept edge.
  task automatic issue(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] m, input logic [2:0] f, input logic [4:0] rd);
    mem_write_in = we; mem_read_in = re; mem_addr_in = a; mem_data_in = d;
    mem_mask_in = m; funct3_in = f; rd_in = rd;
    @(posedge clk); #1;
    mem_write_in = 1'b0; mem_read_in = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({stall_out, dbus_req_out, dbus_we_out, dbus_addr_out, dbus_wdata_out, dbus_wstrb_out,
         load_valid_out, load_data_out, load_rd_out, misalign_out, timeout_out} !== '0) begin
      errors++;
      $display("FAIL %s: stall=%b req=%b we=%b addr=%h wdata=%h wstrb=%h lv=%b ld=%h rd=%0d mis=%b to=%b, required all 0",
               name, stall_out, dbus_req_out, dbus_we_out, dbus_addr_out, dbus_wdata_out, dbus_wstrb_out,
               load_valid_out, load_data_out, load_rd_out, misalign_out, timeout_out);
    end
  endtask

  task automatic do_store(input logic re, input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] m, input logic [2:0] f, input int rdy_wait);
    bus_exp_t e;
    logic [31:0] wd;
    logic [3:0]  ws;
    int stall_cnt;
    wd = d << (8 * a[1:0]);
    ws = m[3:0] << a[1:0];
    e.addr = {a[31:2], 2'b00}; e.wdata = wd; e.wstrb = ws; e.we = 1'b1;
    bus_q.push_back(e);
    issue(1'b1, re, a, d, m, f, 5'd0);
    stall_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (!stall_out) break;
      stall_cnt++;
      dbus_ready_in = (k >= rdy_wait);
      @(posedge clk); #1;
    end
    dbus_ready_in = 1'b0;
    checks++;
    if (stall_cnt != rdy_wait + 1) begin
      errors++;
      $display("FAIL store_stall: got %0d stall cycles, required %0d", stall_cnt, rdy_wait + 1);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] rd,
                         input logic [31:0] rdata, input int rdy_wait, input int rv_wait,
                         input logic rv_with_ready);
    bus_exp_t e;
    ld_exp_t  l;
    e.addr = {a[31:2], 2'b00}; e.wdata = 32'h0; e.wstrb = 4'h0; e.we = 1'b0;
    l.data = model_load(rdata, a[1:0], f); l.rd = rd;
    bus_q.push_back(e);
    ld_q.push_back(l);
    issue(1'b0, 1'b1, a, 32'h0, 8'h0, f, rd);
    for (int k = 0; k < rdy_wait; k++) begin
      @(posedge clk); #1;
    end
    dbus_ready_in = 1'b1; dbus_rvalid_in = rv_with_ready; dbus_rdata_in = ~rdata;
    @(posedge clk); #1;
    dbus_ready_in = 1'b0; dbus_rvalid_in = 1'b0;
    for (int k = 0; k < rv_wait; k++) begin
      @(posedge clk); #1;
    end
    dbus_rvalid_in = 1'b1; dbus_rdata_in = rdata;
    @(posedge clk); #1;
    dbus_rvalid_in = 1'b0; dbus_rdata_in = 32'h0;
    checks++;
    if (load_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: load_valid_out=%b after rvalid edge, required 1", load_valid_out);
    end
    @(posedge clk); #1;
    checks++;
    if (load_valid_out !== 1'b0 || load_data_out !== l.data || load_rd_out !== rd || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL load_hold: lv=%b data=%h rd=%0d stall=%b, required lv=0 data=%h rd=%0d stall=0",
               load_valid_out, load_data_out, load_rd_out, stall_out, l.data, rd);
    end
  endtask

  task automatic expect_misalign(input logic we, input logic [31:0] a, input logic [2:0] f);
    logic [31:0] held;
    held = load_data_out;
    issue(we, !we, a, 32'h0, 8'h0f, f, 5'd9);
    checks++;
    if (misalign_out !== 1'b1 || stall_out !== 1'b0 || dbus_req_out !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse a=%h f=%0d: mis=%b stall=%b req=%b, required mis=1 stall=0 req=0",
               a, f, misalign_out, stall_out, dbus_req_out);
    end
    @(posedge clk); #1;
    checks++;
    if (misalign_out !== 1'b0 || dbus_req_out !== 1'b0 || load_data_out !== held) begin
      errors++;
      $display("FAIL misalign_after a=%h: mis=%b req=%b data=%h, required mis=0 req=0 data=%h",
               a, misalign_out, dbus_req_out, load_data_out, held);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("after_reset_release");
  endtask

  task automatic test_store();
    do_store(1'b0, 32'h0000_1002, 32'h0000_ABCD, 8'h03, 3'd1, 2);
    do_store(1'b0, 32'h0000_1001, 32'h0000_0012, 8'h01, 3'd0, 0);
    do_store(1'b0, 32'h0000_1008, 32'hCAFE_F00D, 8'hFF, 3'd2, 1);
  endtask

  task automatic test_load();
    do_load(32'h0000_2003, 3'd0, 5'd7,  32'h80FF_1234, 0, 0, 1'b0);
    do_load(32'h0000_2002, 3'd5, 5'd12, 32'h80FF_1234, 0, 0, 1'b1);
    do_load(32'h0000_2004, 3'd2, 5'd31, 32'hDEAD_BEEF, 1, 0, 1'b0);
    do_load(32'h0000_2001, 3'd4, 5'd3,  32'h1234_9A78, 0, 1, 1'b0);
    do_load(32'h0000_2002, 3'd1, 5'd1,  32'h8001_FFFF, 0, 1, 1'b1);
  endtask

  task automatic test_misalign();
    expect_misalign(1'b0, 32'h0000_2001, 3'd2);
    expect_misalign(1'b0, 32'h0000_2003, 3'd5);
    expect_misalign(1'b0, 32'h0000_2000, 3'd3);
    expect_misalign(1'b1, 32'h0000_1001, 3'd1);
  endtask

  task automatic test_timeout();
    int req_cycles;
    int to_pulses;
    issue(1'b0, 1'b1, 32'h0000_3000, 32'h0, 8'h0, 3'd2, 5'd4);
    req_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (timeout_out || !stall_out) break;
      if (dbus_req_out) req_cycles++;
      @(posedge clk); #1;
    end
    checks++;
    if (req_cycles != 4 || timeout_out !== 1'b1 || stall_out !== 1'b0 || dbus_req_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d to=%b stall=%b req=%b, required 4 1 0 0",
               req_cycles, timeout_out, stall_out, dbus_req_out);
    end
    to_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (timeout_out) to_pulses++;
    end
    checks++;
    if (to_pulses != 0) begin
      errors++;
      $display("FAIL timeout_single: got %0d extra pulse cycles, required 0", to_pulses);
    end
  endtask

  task automatic test_reset_mid();
    bus_exp_t e;
    e.addr = 32'h0000_2000; e.wdata = 32'h0; e.wstrb = 4'h0; e.we = 1'b0;
    bus_q.push_back(e);
    issue(1'b0, 1'b1, 32'h0000_2000, 32'h0, 8'h0, 3'd2, 5'd3);
    dbus_ready_in = 1'b1;
    @(posedge clk); #1;
    dbus_ready_in = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_in_wait");
    reset = 1'b0;
    dbus_rvalid_in = 1'b1; dbus_rdata_in = 32'h1111_1111;
    @(posedge clk); #1;
    dbus_rvalid_in = 1'b0; dbus_rdata_in = 32'h0;
    for (int k = 0; k < 2; k++) begin
      check_all_zero("after_reset_rvalid");
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_store(1'b1, 32'h0000_1003, 32'h0000_005A, 8'h01, 3'd0, 0);
    do_load(32'h0000_2000, 3'd0, 5'd20, 32'h0000_007F, 0, 0, 1'b0);
    do_store(1'b0, 32'h0000_1006, 32'h0000_BEEF, 8'hF3, 3'd5, 0);
    do_load(32'h0000_2001, 3'd0, 5'd21, 32'h0000_FE00, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    mem_write_in = 1'b0; mem_read_in = 1'b0; mem_addr_in = '0; mem_data_in = '0;
    mem_mask_in = '0; funct3_in = '0; rd_in = '0;
    dbus_ready_in = 1'b0; dbus_rvalid_in = 1'b0; dbus_rdata_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (bus_q.size() != 0 || ld_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: bus=%0d load=%0d pending, required 0 0", bus_q.size(), ld_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
